sb_axil_m_buf: RTL and testbench
================================

# sb_axil_m_buf

Buffered, synthesizable AXI-lite master bridge: five stream ports (AW, W, AR request; B, R response) connect to switchboard queue endpoints, and an AXI-lite master port drives the DUT. Each channel has a parametrised FIFO. Per-direction outstanding-transaction limits are enforced, with an optional AW/W join mode and sticky protocol-error flags. It replaces the bare pass-through master for benches that need backpressure decoupling, reset, and transaction throttling.

## Interface
- DATA_WIDTH, 32, AXI data width
- ADDR_WIDTH, 16, AXI address width
- STRB_WIDTH, DATA_WIDTH/8, write strobe width
- FIFO_DEPTH, 4, entries per channel FIFO; power of two, ≥2
- MAX_WR, 4, maximum outstanding writes (≥1)
- MAX_RD, 4, maximum outstanding reads (≥1)
- WRITE_JOIN, 0, 1 = AW and W are issued as a pair; 0 = independent
- clk  in  1  clock
- nreset  in  1  asynchronous active-low reset
- aw_in_data  in  ADDR_WIDTH+3  {awprot, awaddr}; with aw_in_valid in 1 and aw_in_ready out 1
- w_in_data  in  DATA_WIDTH+STRB_WIDTH  {wstrb, wdata}; with w_in_valid and w_in_ready
- ar_in_data  in  ADDR_WIDTH+3  {arprot, araddr}; with ar_in_valid and ar_in_ready
- b_out_data  out  2  bresp; with b_out_valid out 1 and b_out_ready in 1
- r_out_data  out  DATA_WIDTH+2  {rresp, rdata}; with r_out_valid and r_out_ready
- m_axil_*  AXI-lite master port: aw/w/b/ar/r channels with the standard widths above
- wr_outstanding  out  $clog2(MAX_WR+1)  current outstanding writes
- rd_outstanding  out  $clog2(MAX_RD+1)  current outstanding reads
- wr_err  out  1  sticky: a B beat arrived while wr_outstanding == 0
- rd_err  out  1  sticky: an R beat arrived while rd_outstanding == 0

## Operation
- Each of the five channels has its own FIFO.
  - Push side of every FIFO: ready = !full.
  - Pop side of every FIFO: valid = !empty, subject to the gating below.
  - There is no combinational bypass; FIFO data registers hold their previous contents after a pop.
- Read path:
  - m_axil_arvalid = ar FIFO non-empty && rd_outstanding < MAX_RD.
  - An AR handshake pops the ar FIFO and increments rd_outstanding.
  - m_axil_rready = r FIFO not full. An R handshake pushes to the r FIFO and decrements rd_outstanding, saturating at 0.
- Write path, WRITE_JOIN=0:
  - m_axil_awvalid = aw FIFO non-empty && wr_outstanding < MAX_WR.
  - m_axil_wvalid = w FIFO non-empty; W is not gated by the outstanding count.
  - An AW handshake increments wr_outstanding.
- Write path, WRITE_JOIN=1, two-state FSM:
  - IDLE → PAIR when both aw and w FIFOs are non-empty and wr_outstanding < MAX_WR. awvalid and wvalid assert together on entry.
  - In PAIR, each channel deasserts its valid and pops its FIFO on its own handshake; the other channel's valid is held.
  - PAIR → IDLE when both handshakes have completed; this can happen in the same cycle or across cycles.
  - wr_outstanding increments on the AW handshake.
- B handshake (m_axil_bready = b FIFO not full): pushes to the b FIFO and decrements wr_outstanding, saturating at 0.
- Increment and decrement in the same cycle: the count is unchanged.
- A B or R beat arriving with count 0:
  - the beat is still forwarded;
  - the matching wr_err or rd_err is set and holds until reset.
- Once asserted, an AXI valid is never withdrawn before its handshake, even if the count or FIFO state changes.

## Timing
- Reset (nreset low, asynchronous), effective immediately:
  - all FIFOs empty;
  - all m_axil valids and b_out_valid/r_out_valid = 0;
  - all *_in_ready = 0 while in reset;
  - counts = 0, wr_err = rd_err = 0;
  - FSM in IDLE.
- First rising clk after reset release: *_in_ready = 1, bready = rready = 1.
- Latency:
  - request beat pushed at edge N → AXI valid visible after edge N (cycle N+1 combinational from FIFO state);
  - response handshake at edge N → *_out_valid in cycle N+1.
- Sustained throughput: 1 beat/cycle per channel when not throttled.
- Full FIFO with simultaneous push attempt and pop: in_ready is low for that cycle, so no push occurs.
- Pointers use log2(FIFO_DEPTH)+1 bits; they wrap naturally, and full = MSBs differ with remaining bits equal.
- Reset asserted mid-transaction: in-flight state and counters are discarded; the slave is responsible for its own reset.

## Test plan
- Reset: assert nreset=0 mid-burst → all valids 0 and counts 0 immediately; one cycle after release, aw_in_ready = 1.
- MAX_RD=2, slave arready=1, rvalid held 0, push 3 ARs (0x10, 0x14, 0x18) → two AR handshakes, rd_outstanding = 2, arvalid low with 0x18 pending. One R (data 0xA5A5A5A5, OKAY) → 0x18 issues the next cycle and r_out_data = {2'b00, 0xA5A5A5A5}.
- WRITE_JOIN=1, awready=1 with wready delayed 3 cycles → awvalid drops after its handshake, wvalid held 3 cycles, wr_outstanding = 1, and no new AW issues until W completes.
- FIFO_DEPTH=4, b_out_ready=0, 6 B beats offered → bready falls after 4 accepted; raising b_out_ready drains the 4 beats in order, then the remaining 2 are accepted.
- Unsolicited R beat with rd_outstanding = 0 → rd_err = 1 and stays set; the beat appears on r_out; rd_outstanding stays 0.
- Same-cycle AR handshake and R handshake at count 1 → count stays 1.

Source files
------------

// File: rtl/sb_axil_m_buf.sv
// Buffered AXI-lite master bridge: per-channel FIFOs between switchboard streams and
// an AXI-lite master port, with outstanding-transaction throttling and error flags.

module sb_axil_m_buf_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, rd_ptr_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage is not reset; stale entries are masked by the pointers.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
endmodule

module sb_axil_m_buf #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_WR     = 4,
  parameter int MAX_RD     = 4,
  parameter int WRITE_JOIN = 0
) (
  input  logic                             clk,
  input  logic                             nreset,
  input  logic [ADDR_WIDTH+2:0]            aw_in_data,
  input  logic                             aw_in_valid,
  output logic                             aw_in_ready,
  input  logic [DATA_WIDTH+STRB_WIDTH-1:0] w_in_data,
  input  logic                             w_in_valid,
  output logic                             w_in_ready,
  input  logic [ADDR_WIDTH+2:0]            ar_in_data,
  input  logic                             ar_in_valid,
  output logic                             ar_in_ready,
  output logic [1:0]                       b_out_data,
  output logic                             b_out_valid,
  input  logic                             b_out_ready,
  output logic [DATA_WIDTH+1:0]            r_out_data,
  output logic                             r_out_valid,
  input  logic                             r_out_ready,
  output logic [ADDR_WIDTH-1:0]            m_axil_awaddr,
  output logic [2:0]                       m_axil_awprot,
  output logic                             m_axil_awvalid,
  input  logic                             m_axil_awready,
  output logic [DATA_WIDTH-1:0]            m_axil_wdata,
  output logic [STRB_WIDTH-1:0]            m_axil_wstrb,
  output logic                             m_axil_wvalid,
  input  logic                             m_axil_wready,
  input  logic [1:0]                       m_axil_bresp,
  input  logic                             m_axil_bvalid,
  output logic                             m_axil_bready,
  output logic [ADDR_WIDTH-1:0]            m_axil_araddr,
  output logic [2:0]                       m_axil_arprot,
  output logic                             m_axil_arvalid,
  input  logic                             m_axil_arready,
  input  logic [DATA_WIDTH-1:0]            m_axil_rdata,
  input  logic [1:0]                       m_axil_rresp,
  input  logic                             m_axil_rvalid,
  output logic                             m_axil_rready,
  output logic [$clog2(MAX_WR+1)-1:0]      wr_outstanding,
  output logic [$clog2(MAX_RD+1)-1:0]      rd_outstanding,
  output logic                             wr_err,
  output logic                             rd_err
);
  localparam int WCW = $clog2(MAX_WR+1);
  localparam int RCW = $clog2(MAX_RD+1);
  localparam int AWW = ADDR_WIDTH + 3;
  localparam int WW  = DATA_WIDTH + STRB_WIDTH;
  localparam int RW  = DATA_WIDTH + 2;

  // Readies stay low through reset and rise on the first clock after release.
  logic alive_q;
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) alive_q <= 1'b0;
    else         alive_q <= 1'b1;
  end

  logic aw_full, aw_empty, w_full, w_empty, ar_full, ar_empty;
  logic b_full, b_empty, r_full, r_empty;
  logic [AWW-1:0] aw_dout, ar_dout;
  logic [WW-1:0]  w_dout;
  logic           aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic           aw_vld, w_vld;

  assign aw_in_ready   = alive_q && !aw_full;
  assign w_in_ready    = alive_q && !w_full;
  assign ar_in_ready   = alive_q && !ar_full;
  assign m_axil_bready = alive_q && !b_full;
  assign m_axil_rready = alive_q && !r_full;

  assign aw_hs = m_axil_awvalid && m_axil_awready;
  assign w_hs  = m_axil_wvalid  && m_axil_wready;
  assign ar_hs = m_axil_arvalid && m_axil_arready;
  assign b_hs  = m_axil_bvalid  && m_axil_bready;
  assign r_hs  = m_axil_rvalid  && m_axil_rready;

  sb_axil_m_buf_fifo #(.W(AWW), .DEPTH(FIFO_DEPTH)) u_aw_fifo (
    .clk(clk), .nreset(nreset), .push_i(aw_in_valid && aw_in_ready), .din_i(aw_in_data),
    .pop_i(aw_hs), .dout_o(aw_dout), .full_o(aw_full), .empty_o(aw_empty));

  sb_axil_m_buf_fifo #(.W(WW), .DEPTH(FIFO_DEPTH)) u_w_fifo (
    .clk(clk), .nreset(nreset), .push_i(w_in_valid && w_in_ready), .din_i(w_in_data),
    .pop_i(w_hs), .dout_o(w_dout), .full_o(w_full), .empty_o(w_empty));

  sb_axil_m_buf_fifo #(.W(AWW), .DEPTH(FIFO_DEPTH)) u_ar_fifo (
    .clk(clk), .nreset(nreset), .push_i(ar_in_valid && ar_in_ready), .din_i(ar_in_data),
    .pop_i(ar_hs), .dout_o(ar_dout), .full_o(ar_full), .empty_o(ar_empty));

  sb_axil_m_buf_fifo #(.W(2), .DEPTH(FIFO_DEPTH)) u_b_fifo (
    .clk(clk), .nreset(nreset), .push_i(b_hs), .din_i(m_axil_bresp),
    .pop_i(b_out_valid && b_out_ready), .dout_o(b_out_data), .full_o(b_full),
    .empty_o(b_empty));

  sb_axil_m_buf_fifo #(.W(RW), .DEPTH(FIFO_DEPTH)) u_r_fifo (
    .clk(clk), .nreset(nreset), .push_i(r_hs), .din_i({m_axil_rresp, m_axil_rdata}),
    .pop_i(r_out_valid && r_out_ready), .dout_o(r_out_data), .full_o(r_full),
    .empty_o(r_empty));

  assign b_out_valid = !b_empty;
  assign r_out_valid = !r_empty;

  assign {m_axil_awprot, m_axil_awaddr} = aw_dout;
  assign {m_axil_wstrb, m_axil_wdata}   = w_dout;
  assign {m_axil_arprot, m_axil_araddr} = ar_dout;

  logic [WCW-1:0] wr_cnt_q, wr_cnt_d;
  logic [RCW-1:0] rd_cnt_q, rd_cnt_d;
  logic           wr_err_q, wr_err_d, rd_err_q, rd_err_d;
  logic           wr_ok, rd_ok;

  assign wr_ok = (wr_cnt_q < WCW'(MAX_WR));
  assign rd_ok = (rd_cnt_q < RCW'(MAX_RD));

  // Count-gated valids cannot drop early: the count only rises on their own handshake.
  assign m_axil_arvalid = !ar_empty && rd_ok;

  if (WRITE_JOIN != 0) begin : g_join
    typedef enum logic {IDLE, PAIR} state_e;
    state_e state_q;
    logic   aw_pend_q, w_pend_q;

    always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
        state_q   <= IDLE;
        aw_pend_q <= 1'b0;
        w_pend_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (!aw_empty && !w_empty && wr_ok) begin
              state_q   <= PAIR;
              aw_pend_q <= 1'b1;
              w_pend_q  <= 1'b1;
            end
          end
          PAIR: begin
            if (aw_hs) aw_pend_q <= 1'b0;
            if (w_hs)  w_pend_q  <= 1'b0;
            if ((aw_hs || !aw_pend_q) && (w_hs || !w_pend_q)) state_q <= IDLE;
          end
        endcase
      end
    end

    assign aw_vld = aw_pend_q;
    assign w_vld  = w_pend_q;
  end else begin : g_indep
    assign aw_vld = !aw_empty && wr_ok;
    assign w_vld  = !w_empty;
  end

  assign m_axil_awvalid = aw_vld;
  assign m_axil_wvalid  = w_vld;

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (aw_hs && !b_hs)                        wr_cnt_d = wr_cnt_q + WCW'(1);
    else if (!aw_hs && b_hs && wr_cnt_q != '0) wr_cnt_d = wr_cnt_q - WCW'(1);
    rd_cnt_d = rd_cnt_q;
    if (ar_hs && !r_hs)                        rd_cnt_d = rd_cnt_q + RCW'(1);
    else if (!ar_hs && r_hs && rd_cnt_q != '0) rd_cnt_d = rd_cnt_q - RCW'(1);
    wr_err_d = wr_err_q || (b_hs && wr_cnt_q == '0);
    rd_err_d = rd_err_q || (r_hs && rd_cnt_q == '0);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      wr_err_q <= wr_err_d;
      rd_err_q <= rd_err_d;
    end
  end

  assign wr_outstanding = wr_cnt_q;
  assign rd_outstanding = rd_cnt_q;
  assign wr_err         = wr_err_q;
  assign rd_err         = rd_err_q;
endmodule

// File: tb/tb_sb_axil_m_buf.sv
// Directed bench: instance "a" runs independent writes with MAX_RD=MAX_WR=2,
// instance "j" runs the joined AW/W write path.
`timescale 1ns/1ps
module tb_sb_axil_m_buf;
  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // instance a
  logic [18:0] a_aw_in_data, a_ar_in_data;
  logic [35:0] a_w_in_data;
  logic        a_aw_in_valid, a_aw_in_ready, a_w_in_valid, a_w_in_ready;
  logic        a_ar_in_valid, a_ar_in_ready;
  logic [1:0]  a_b_out_data;
  logic        a_b_out_valid, a_b_out_ready;
  logic [33:0] a_r_out_data;
  logic        a_r_out_valid, a_r_out_ready;
  logic [15:0] a_awaddr, a_araddr;
  logic [2:0]  a_awprot, a_arprot;
  logic        a_awvalid, a_awready, a_wvalid, a_wready;
  logic [31:0] a_wdata, a_rdata;
  logic [3:0]  a_wstrb;
  logic [1:0]  a_bresp, a_rresp;
  logic        a_bvalid, a_bready, a_arvalid, a_arready, a_rvalid, a_rready;
  logic [1:0]  a_wr_outstanding, a_rd_outstanding;
  logic        a_wr_err, a_rd_err;

  // instance j
  logic [18:0] j_aw_in_data, j_ar_in_data;
  logic [35:0] j_w_in_data;
  logic        j_aw_in_valid, j_aw_in_ready, j_w_in_valid, j_w_in_ready;
  logic        j_ar_in_valid, j_ar_in_ready;
  logic [1:0]  j_b_out_data;
  logic        j_b_out_valid, j_b_out_ready;
  logic [33:0] j_r_out_data;
  logic        j_r_out_valid, j_r_out_ready;
  logic [15:0] j_awaddr, j_araddr;
  logic [2:0]  j_awprot, j_arprot;
  logic        j_awvalid, j_awready, j_wvalid, j_wready;
  logic [31:0] j_wdata, j_rdata;
  logic [3:0]  j_wstrb;
  logic [1:0]  j_bresp, j_rresp;
  logic        j_bvalid, j_bready, j_arvalid, j_arready, j_rvalid, j_rready;
  logic [2:0]  j_wr_outstanding, j_rd_outstanding;
  logic        j_wr_err, j_rd_err;

  sb_axil_m_buf #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .FIFO_DEPTH(4), .MAX_WR(2), .MAX_RD(2),
                  .WRITE_JOIN(0)) u_a (
    .clk(clk), .nreset(nreset),
    .aw_in_data(a_aw_in_data), .aw_in_valid(a_aw_in_valid), .aw_in_ready(a_aw_in_ready),
    .w_in_data(a_w_in_data), .w_in_valid(a_w_in_valid), .w_in_ready(a_w_in_ready),
    .ar_in_data(a_ar_in_data), .ar_in_valid(a_ar_in_valid), .ar_in_ready(a_ar_in_ready),
    .b_out_data(a_b_out_data), .b_out_valid(a_b_out_valid), .b_out_ready(a_b_out_ready),
    .r_out_data(a_r_out_data), .r_out_valid(a_r_out_valid), .r_out_ready(a_r_out_ready),
    .m_axil_awaddr(a_awaddr), .m_axil_awprot(a_awprot), .m_axil_awvalid(a_awvalid),
    .m_axil_awready(a_awready), .m_axil_wdata(a_wdata), .m_axil_wstrb(a_wstrb),
    .m_axil_wvalid(a_wvalid), .m_axil_wready(a_wready), .m_axil_bresp(a_bresp),
    .m_axil_bvalid(a_bvalid), .m_axil_bready(a_bready), .m_axil_araddr(a_araddr),
    .m_axil_arprot(a_arprot), .m_axil_arvalid(a_arvalid), .m_axil_arready(a_arready),
    .m_axil_rdata(a_rdata), .m_axil_rresp(a_rresp), .m_axil_rvalid(a_rvalid),
    .m_axil_rready(a_rready), .wr_outstanding(a_wr_outstanding),
    .rd_outstanding(a_rd_outstanding), .wr_err(a_wr_err), .rd_err(a_rd_err));

  sb_axil_m_buf #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .FIFO_DEPTH(4), .MAX_WR(4), .MAX_RD(4),
                  .WRITE_JOIN(1)) u_j (
    .clk(clk), .nreset(nreset),
    .aw_in_data(j_aw_in_data), .aw_in_valid(j_aw_in_valid), .aw_in_ready(j_aw_in_ready),
    .w_in_data(j_w_in_data), .w_in_valid(j_w_in_valid), .w_in_ready(j_w_in_ready),
    .ar_in_data(j_ar_in_data), .ar_in_valid(j_ar_in_valid), .ar_in_ready(j_ar_in_ready),
    .b_out_data(j_b_out_data), .b_out_valid(j_b_out_valid), .b_out_ready(j_b_out_ready),
    .r_out_data(j_r_out_data), .r_out_valid(j_r_out_valid), .r_out_ready(j_r_out_ready),
    .m_axil_awaddr(j_awaddr), .m_axil_awprot(j_awprot), .m_axil_awvalid(j_awvalid),
    .m_axil_awready(j_awready), .m_axil_wdata(j_wdata), .m_axil_wstrb(j_wstrb),
    .m_axil_wvalid(j_wvalid), .m_axil_wready(j_wready), .m_axil_bresp(j_bresp),
    .m_axil_bvalid(j_bvalid), .m_axil_bready(j_bready), .m_axil_araddr(j_araddr),
    .m_axil_arprot(j_arprot), .m_axil_arvalid(j_arvalid), .m_axil_arready(j_arready),
    .m_axil_rdata(j_rdata), .m_axil_rresp(j_rresp), .m_axil_rvalid(j_rvalid),
    .m_axil_rready(j_rready), .wr_outstanding(j_wr_outstanding),
    .rd_outstanding(j_rd_outstanding), .wr_err(j_wr_err), .rd_err(j_rd_err));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int   k, n;
  logic acc;

  initial begin
    a_aw_in_data = '0; a_aw_in_valid = 0; a_w_in_data = '0; a_w_in_valid = 0;
    a_ar_in_data = '0; a_ar_in_valid = 0; a_b_out_ready = 0; a_r_out_ready = 0;
    a_awready = 0; a_wready = 0; a_bresp = 0; a_bvalid = 0; a_arready = 0;
    a_rdata = '0; a_rresp = 0; a_rvalid = 0;
    j_aw_in_data = '0; j_aw_in_valid = 0; j_w_in_data = '0; j_w_in_valid = 0;
    j_ar_in_data = '0; j_ar_in_valid = 0; j_b_out_ready = 0; j_r_out_ready = 0;
    j_awready = 0; j_wready = 0; j_bresp = 0; j_bvalid = 0; j_arready = 0;
    j_rdata = '0; j_rresp = 0; j_rvalid = 0;

    #2;
    chk("rst_aw_in_ready", a_aw_in_ready, 0);
    chk("rst_arvalid", a_arvalid, 0);
    chk("rst_rd_out", a_rd_outstanding, 0);
    chk("rst_bready", a_bready, 0);
    repeat (2) @(posedge clk);
    #1 nreset = 1;
    tick();
    chk("rel_aw_in_ready", a_aw_in_ready, 1);
    chk("rel_bready", a_bready, 1);
    chk("rel_rready", a_rready, 1);

    // ---------------- joined write path ----------------
    j_awready = 1; j_wready = 0;
    j_aw_in_valid = 1; j_aw_in_data = {3'b000, 16'h0200};
    j_w_in_valid = 1;  j_w_in_data = {4'hF, 32'hAAAA0001};
    tick();
    chk("j_idle_awvalid", j_awvalid, 0);
    j_aw_in_data = {3'b000, 16'h0204};
    j_w_in_data = {4'hF, 32'hAAAA0002};
    tick();
    j_aw_in_valid = 0; j_w_in_valid = 0;
    chk("j_pair_awvalid", j_awvalid, 1);
    chk("j_pair_wvalid", j_wvalid, 1);
    chk("j_pair_awaddr", j_awaddr, 16'h0200);
    chk("j_pair_wdata", j_wdata, 32'hAAAA0001);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("j_aw_dropped", j_awvalid, 0);
      chk("j_w_held", j_wvalid, 1);
      chk("j_wr_out_1", j_wr_outstanding, 1);
    end
    j_wready = 1;
    tick();
    j_wready = 0;
    chk("j_after_w_awvalid", j_awvalid, 0);
    chk("j_after_w_wvalid", j_wvalid, 0);
    tick();
    chk("j_pair2_awvalid", j_awvalid, 1);
    chk("j_pair2_awaddr", j_awaddr, 16'h0204);
    chk("j_pair2_wdata", j_wdata, 32'hAAAA0002);
    j_wready = 1;
    tick();
    j_wready = 0;
    chk("j_both_hs_awvalid", j_awvalid, 0);
    chk("j_both_hs_wvalid", j_wvalid, 0);
    chk("j_wr_out_2", j_wr_outstanding, 2);
    j_bvalid = 1;
    tick();
    j_bvalid = 0;
    chk("j_b_dec", j_wr_outstanding, 1);
    chk("j_wr_err", j_wr_err, 0);

    // ---------------- read path, MAX_RD=2 ----------------
    a_arready = 1; a_rvalid = 0;
    a_ar_in_valid = 1; a_ar_in_data = {3'b000, 16'h0010};
    tick();
    chk("ar_first", a_araddr, 16'h0010);
    a_ar_in_data = {3'b000, 16'h0014};
    tick();
    chk("ar_second", a_araddr, 16'h0014);
    chk("rd_out_1", a_rd_outstanding, 1);
    a_ar_in_data = {3'b000, 16'h0018};
    tick();
    a_ar_in_valid = 0;
    chk("ar_throttled", a_arvalid, 0);
    chk("ar_pending", a_araddr, 16'h0018);
    chk("rd_out_2", a_rd_outstanding, 2);
    tick();
    chk("ar_still_throttled", a_arvalid, 0);
    a_rvalid = 1; a_rdata = 32'hA5A5A5A5; a_rresp = 2'b00;
    tick();
    a_rvalid = 0;
    chk("ar_reissue", a_arvalid, 1);
    chk("ar_reissue_addr", a_araddr, 16'h0018);
    chk("r_out_valid", a_r_out_valid, 1);
    chk("r_out_data", a_r_out_data, {2'b00, 32'hA5A5A5A5});
    chk("rd_out_after_r", a_rd_outstanding, 1);
    a_r_out_ready = 1;
    tick();
    chk("ar_issued", a_arvalid, 0);
    chk("rd_out_2b", a_rd_outstanding, 2);
    a_rvalid = 1; a_rdata = 32'h1;
    tick();
    a_rvalid = 0;
    chk("rd_out_dec", a_rd_outstanding, 1);
    a_ar_in_valid = 1; a_ar_in_data = {3'b000, 16'h0020};
    tick();
    a_ar_in_valid = 0;
    chk("ar_third_valid", a_arvalid, 1);
    a_rvalid = 1; a_rdata = 32'h2;
    tick();
    chk("rd_same_cycle", a_rd_outstanding, 1);
    a_rdata = 32'h3;
    tick();
    chk("rd_out_0", a_rd_outstanding, 0);
    chk("rd_err_clear", a_rd_err, 0);
    a_rdata = 32'hDEADBEEF; a_rresp = 2'b10;
    tick();
    a_rvalid = 0;
    chk("rd_err_set", a_rd_err, 1);
    chk("rd_out_stays_0", a_rd_outstanding, 0);
    chk("r_unsolicited_fwd", a_r_out_data, {2'b10, 32'hDEADBEEF});
    repeat (2) tick();
    chk("rd_err_sticky", a_rd_err, 1);

    // ---------------- B backpressure ----------------
    k = 0; a_bvalid = 1; a_bresp = 2'd0;
    repeat (6) begin
      acc = a_bready;
      tick();
      if (acc && a_bvalid) begin
        k++;
        if (k < 6) a_bresp = 2'(k % 4); else a_bvalid = 0;
      end
    end
    chk("b_accepted_4", k, 4);
    chk("bready_full", a_bready, 0);
    a_b_out_ready = 1; n = 0;
    for (int c = 0; c < 30 && n < 6; c++) begin
      if (a_b_out_valid) begin
        chk("b_order", a_b_out_data, 64'(n % 4));
        n++;
      end
      acc = a_bready;
      tick();
      if (acc && a_bvalid) begin
        k++;
        if (k < 6) a_bresp = 2'(k % 4); else a_bvalid = 0;
      end
    end
    chk("b_drained", n, 6);
    chk("wr_err_set", a_wr_err, 1);
    chk("wr_out_0", a_wr_outstanding, 0);

    // ---------------- independent AW/W, MAX_WR=2 ----------------
    a_awready = 1; a_wready = 0;
    a_aw_in_valid = 1; a_aw_in_data = {3'b000, 16'h0100};
    a_w_in_valid = 1;  a_w_in_data = {4'hF, 32'h11111111};
    tick();
    a_w_in_valid = 0;
    a_aw_in_data = {3'b000, 16'h0104};
    chk("w_valid_indep", a_wvalid, 1);
    chk("w_data", a_wdata, 32'h11111111);
    chk("aw_first", a_awaddr, 16'h0100);
    tick();
    a_aw_in_data = {3'b000, 16'h0108};
    tick();
    a_aw_in_valid = 0;
    chk("wr_out_max", a_wr_outstanding, 2);
    chk("aw_throttled", a_awvalid, 0);
    chk("aw_pending", a_awaddr, 16'h0108);
    chk("w_not_gated", a_wvalid, 1);

    // ---------------- reset mid-transaction ----------------
    nreset = 0;
    #1;
    chk("mid_rst_wvalid", a_wvalid, 0);
    chk("mid_rst_wr_out", a_wr_outstanding, 0);
    chk("mid_rst_wr_err", a_wr_err, 0);
    chk("mid_rst_rd_err", a_rd_err, 0);
    chk("mid_rst_aw_in_ready", a_aw_in_ready, 0);
    chk("mid_rst_j_wr_out", j_wr_outstanding, 0);
    @(posedge clk);
    #1 nreset = 1;
    tick();
    chk("post_rst_aw_in_ready", a_aw_in_ready, 1);
    chk("post_rst_awvalid", a_awvalid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
